// File: rtl/alpha_periph_bram_burst.sv
// alpha_periph_bram_burst: byte-addressed BRAM on the packet bus with a
// line-burst sequencer and a configurable read latency (RD_LAT).
// Ports: clk, reset_n (async, active low), mem_req_pkt_xx in,
//        mem_req_ack_xx out (combinational), mem_resp_pkt_xx out (registered).
// Option: define ALPHA_BRAM_STORE_RESP_EN to return a response per store beat.
// Packet layout: VLD[102] LAST[101] TYPE[100:99] SIZE[98:96]
//                ADDR[95:64] DATA[63:0].

`ifndef PKT_BITS
`define PKT_BITS 103
`endif
`ifndef PKT_VLD
`define PKT_VLD 102
`endif
`ifndef PKT_LAST
`define PKT_LAST 101
`endif
`ifndef PKT_TYPE
`define PKT_TYPE 100:99
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 98:96
`endif
`ifndef PKT_ADDR
`define PKT_ADDR 95:64
`endif
`ifndef PKT_DATA
`define PKT_DATA 63:0
`endif
`ifndef PKT_TYPE_LOAD
`define PKT_TYPE_LOAD 2'd0
`endif
`ifndef PKT_TYPE_STORE
`define PKT_TYPE_STORE 2'd1
`endif
`ifndef PKT_TYPE_FETCH
`define PKT_TYPE_FETCH 2'd2
`endif
`ifndef REQ_SZ_BYTE
`define REQ_SZ_BYTE 3'd0
`endif
`ifndef REQ_SZ_WORD
`define REQ_SZ_WORD 3'd1
`endif
`ifndef REQ_SZ_LWRD
`define REQ_SZ_LWRD 3'd2
`endif
`ifndef REQ_SZ_DWRD
`define REQ_SZ_DWRD 3'd3
`endif
`ifndef REQ_SZ_LINE
`define REQ_SZ_LINE 3'd4
`endif

module alpha_periph_bram_burst #(
   parameter int ADDR_BITS  = 17,
   parameter int LINE_BEATS = 2,
   parameter int RD_LAT     = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [`PKT_BITS-1:0] mem_req_pkt_xx,
   output logic                 mem_req_ack_xx,
   output logic [`PKT_BITS-1:0] mem_resp_pkt_xx
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [31:0] LINE_MASK = 32'(LINE_BEATS * 8 - 1);
   localparam logic [2:0]  LAST_BEAT = 3'(LINE_BEATS - 1);

`ifdef ALPHA_BRAM_STORE_RESP_EN
   localparam bit STORE_RESP = 1'b1;
`else
   localparam bit STORE_RESP = 1'b0;
`endif

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [2:0]  cnt_q;
   logic [2:0]  cnt_d;
   logic        latch;
   logic        ack;

   logic [31:0] base_q;
   logic [1:0]  type_q;
   logic [2:0]  size_q;
   logic [63:0] data_q;

   logic        req_vld;
   logic        req_line;
   logic [31:0] req_addr;
   logic [1:0]  req_type;
   logic [2:0]  req_size;
   logic [63:0] req_data;

   logic        beat_vld;
   logic        beat_last;
   logic [31:0] beat_addr;
   logic [1:0]  beat_type;
   logic [2:0]  beat_size;
   logic [63:0] beat_data;

   assign req_vld  = mem_req_pkt_xx[`PKT_VLD];
   assign req_addr = mem_req_pkt_xx[`PKT_ADDR];
   assign req_type = mem_req_pkt_xx[`PKT_TYPE];
   assign req_size = mem_req_pkt_xx[`PKT_SIZE];
   assign req_data = mem_req_pkt_xx[`PKT_DATA];
   assign req_line = (req_size == `REQ_SZ_LINE);

   assign mem_req_ack_xx = ack;

   // Sequencer: beat 0 goes out in the accept cycle, the rest from
   // the latched request while in BURST.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      latch     = 1'b0;
      ack       = 1'b0;
      beat_vld  = 1'b0;
      beat_last = 1'b0;
      beat_addr = '0;
      beat_type = '0;
      beat_size = '0;
      beat_data = '0;
      unique case (state_q)
         IDLE: begin
            ack = reset_n & req_vld;
            if (ack) begin
               beat_vld  = 1'b1;
               beat_type = req_type;
               beat_size = req_size;
               beat_data = req_data;
               if (req_line) begin
                  beat_addr = req_addr & ~LINE_MASK;
                  beat_last = (LINE_BEATS == 1);
                  if (LINE_BEATS > 1) begin
                     latch   = 1'b1;
                     cnt_d   = 3'd1;
                     state_d = BURST;
                  end
               end else begin
                  beat_addr = req_addr;
                  beat_last = 1'b1;
               end
            end
         end
         BURST: begin
            beat_vld  = 1'b1;
            beat_type = type_q;
            beat_size = size_q;
            beat_data = data_q;
            beat_addr = base_q + {26'b0, cnt_q, 3'b000};
            beat_last = (cnt_q == LAST_BEAT);
            if (beat_last) begin
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         type_q  <= '0;
         size_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            base_q <= req_addr & ~LINE_MASK;
            type_q <= req_type;
            size_q <= req_size;
            data_q <= req_data;
         end
      end
   end

   logic                 is_store;
   logic                 is_read;
   logic                 rsp_en;
   logic [7:0]           be_base;
   logic [15:0]          be_wide;
   logic [7:0]           be;
   logic [63:0]          wdata;
   logic [ADDR_BITS-4:0] word;

   assign is_store = beat_vld
                   & (beat_type == `PKT_TYPE_STORE);
   assign is_read  = beat_vld
                   & ((beat_type == `PKT_TYPE_LOAD)
                   |  (beat_type == `PKT_TYPE_FETCH));
   assign rsp_en   = beat_vld & (~is_store | STORE_RESP);
   assign word     = beat_addr[ADDR_BITS-1:3];

   always_comb begin
      be_base = 8'hFF;
      unique case (1'b1)
         beat_size == `REQ_SZ_BYTE: be_base = 8'h01;
         beat_size == `REQ_SZ_WORD: be_base = 8'h03;
         beat_size == `REQ_SZ_LWRD: be_base = 8'h0F;
         default:                   be_base = 8'hFF;
      endcase
   end

   // Enables that spill past lane 7 fall into be_wide[15:8] and are
   // dropped, so a store never touches the next doubleword.
   assign be_wide = {8'h00, be_base} << beat_addr[2:0];
   assign be      = be_wide[7:0];
   assign wdata   = beat_data << {beat_addr[2:0], 3'b000};

   logic [7:0]  mem [DEPTH];
   logic [63:0] rd_q;

   // RAM has no reset so its contents survive reset_n.
   always_ff @(posedge clk) begin
      if (is_store) begin
         for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
               mem[{word, 3'(i)}] <= wdata[8*i +: 8];
            end
         end
      end
      if (is_read) begin
         for (int i = 0; i < 8; i++) begin
            rd_q[8*i +: 8] <= mem[{word, 3'(i)}];
         end
      end
   end

   logic        s0_vld;
   logic        s0_last;
   logic        s0_rd;
   logic [1:0]  s0_type;
   logic [2:0]  s0_size;
   logic [31:0] s0_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0_vld  <= 1'b0;
         s0_last <= 1'b0;
         s0_rd   <= 1'b0;
         s0_type <= '0;
         s0_size <= '0;
         s0_addr <= '0;
      end else begin
         s0_vld  <= rsp_en;
         s0_last <= rsp_en & beat_last;
         s0_rd   <= rsp_en & is_read;
         s0_type <= rsp_en ? beat_type : 2'b00;
         s0_size <= rsp_en ? beat_size : 3'b000;
         s0_addr <= rsp_en ? beat_addr : 32'h0;
      end
   end

   logic [`PKT_BITS-1:0] s0_pkt;

   // Data is gated here so non-read slots never expose stale RAM output.
   always_comb begin
      s0_pkt            = '0;
      s0_pkt[`PKT_VLD]  = s0_vld;
      s0_pkt[`PKT_LAST] = s0_last;
      s0_pkt[`PKT_TYPE] = s0_type;
      s0_pkt[`PKT_SIZE] = s0_size;
      s0_pkt[`PKT_ADDR] = s0_addr;
      s0_pkt[`PKT_DATA] = s0_rd ? rd_q : 64'h0;
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign mem_resp_pkt_xx = s0_pkt;
      end else begin : g_latn
         logic [`PKT_BITS-1:0] dly_q [RD_LAT-1];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < RD_LAT - 1; i++) begin
                  dly_q[i] <= '0;
               end
            end else begin
               dly_q[0] <= s0_pkt;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  dly_q[i] <= dly_q[i-1];
               end
            end
         end

         assign mem_resp_pkt_xx = dly_q[RD_LAT-2];
      end
   endgenerate

   logic unused_bits;
   assign unused_bits = ^{mem_req_pkt_xx[`PKT_LAST],
                          beat_addr[31:ADDR_BITS],
                          be_wide[15:8]};

endmodule
